ahb_des_queue_slave: RTL and testbench

//  Next-generation AHB-Lite slave front end for the Triple DES core: memory-mapped key/control regs,

---
 rtl/ahb_des_queue_slave.sv | 215 +++++++++++++++++++++
 tb/tb_ahb_des_queue_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_des_queue_slave.sv
// AHB-Lite slave front end for the Triple DES core: key/control registers,
// input/output block queues and a dispatcher that keeps the core fed.
module ahb_des_queue_slave #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [63:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [63:0]       HRDATA,
    output logic              core_start,
    output logic              core_mode,
    output logic [63:0]       core_data,
    output logic [63:0]       core_key1,
    output logic [63:0]       core_key2,
    output logic [63:0]       core_key3,
    input  logic              core_done,
    input  logic [63:0]       core_result,
    output logic              irq
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    localparam logic [2:0] IX_CTRL = 3'd0, IX_STAT = 3'd1, IX_KEY1 = 3'd2, IX_KEY2 = 3'd3,
                           IX_KEY3 = 3'd4, IX_DIN  = 3'd5, IX_DOUT = 3'd6, IX_NONE = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_mode, r_irq_en;
    logic [63:0]     r_key1, r_key2, r_key3;
    logic [63:0]     r_in_mem  [FIFO_DEPTH];
    logic [63:0]     r_out_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_in_wp, r_in_rp, r_out_wp, r_out_rp;
    logic [CW-1:0]   r_in_cnt, r_out_cnt;
    logic            r_dp_wr, r_dp_rd, r_err1, r_err2;
    logic [2:0]      r_dp_idx;

    logic            w_acc, w_err, w_flush;
    logic            w_bus_push, w_bus_pop, w_disp_pop, w_core_push;
    logic [CW-1:0]   w_in_nxt, w_out_nxt;
    logic [2:0]      w_idx;
    logic [63:0]     w_status;
    logic            w_unused;

    assign w_unused = ^{HADDR[ADDR_W-1:6], HTRANS[0]};

    assign w_acc = HSEL & HTRANS[1] & HREADY;
    assign w_idx = HADDR[5:3];

    // Data-phase side effects of the previous accepted (error-free) access
    assign w_flush    = r_dp_wr & (r_dp_idx == IX_CTRL) & HWDATA[2];
    assign w_bus_push = r_dp_wr & (r_dp_idx == IX_DIN);
    assign w_bus_pop  = r_dp_rd & (r_dp_idx == IX_DOUT);

    assign w_disp_pop  = (r_state == S_IDLE) & (r_in_cnt != '0) & (r_out_cnt < DEPTH) & ~w_flush;
    assign w_core_push = (r_state == S_BUSY) & core_done & ~w_flush;

    // Occupancy at the start of the next cycle, i.e. what a new access will see in its data phase
    assign w_in_nxt  = w_flush ? '0 : r_in_cnt + CW'(w_bus_push) - CW'(w_disp_pop);
    assign w_out_nxt = w_flush ? '0 : r_out_cnt + CW'(w_core_push) - CW'(w_bus_pop);

    assign w_err = (HSIZE != 3'b011) | (HADDR[2:0] != 3'b000) | (w_idx == IX_NONE)
                 | ( HWRITE & ((w_idx == IX_STAT) | (w_idx == IX_DOUT)))
                 | (~HWRITE & (w_idx == IX_DIN))
                 | ( HWRITE & (w_idx == IX_DIN)  & (w_in_nxt == DEPTH))
                 | (~HWRITE & (w_idx == IX_DOUT) & (w_out_nxt == '0));

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_dp_wr  <= 1'b0;
            r_dp_rd  <= 1'b0;
            r_dp_idx <= '0;
            r_err1   <= 1'b0;
            r_err2   <= 1'b0;
        end else begin
            r_dp_wr  <= w_acc & ~w_err & HWRITE;
            r_dp_rd  <= w_acc & ~w_err & ~HWRITE;
            r_dp_idx <= w_idx;
            r_err1   <= w_acc & w_err;
            r_err2   <= r_err1;
        end
    end

    assign HREADYOUT = ~r_err1;
    assign HRESP     = r_err1 | r_err2;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_mode   <= 1'b0;
            r_irq_en <= 1'b0;
            r_key1   <= '0;
            r_key2   <= '0;
            r_key3   <= '0;
        end else if (r_dp_wr) begin
            case (r_dp_idx)
                IX_CTRL: begin
                    r_mode   <= HWDATA[0];
                    r_irq_en <= HWDATA[1];
                end
                IX_KEY1: r_key1 <= HWDATA;
                IX_KEY2: r_key2 <= HWDATA;
                IX_KEY3: r_key3 <= HWDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_bus_push)  r_in_mem[r_in_wp]   <= HWDATA;
        if (w_core_push) r_out_mem[r_out_wp] <= core_result;
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_in_wp   <= '0;
            r_in_rp   <= '0;
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_flush) begin
            r_in_wp   <= '0;
            r_in_rp   <= '0;
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_bus_push)  r_in_wp  <= r_in_wp + 1'b1;
            if (w_disp_pop)  r_in_rp  <= r_in_rp + 1'b1;
            if (w_core_push) r_out_wp <= r_out_wp + 1'b1;
            if (w_bus_pop)   r_out_rp <= r_out_rp + 1'b1;
            r_in_cnt  <= w_in_nxt;
            r_out_cnt <= w_out_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // A flush during BUSY still has to wait for the core, whose result is then dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_disp_pop) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (w_flush)        w_state_nxt = core_done ? S_IDLE : S_DRAIN;
                else if (core_done) w_state_nxt = S_IDLE;
            end
            S_DRAIN: if (core_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            core_data  <= '0;
            core_key1  <= '0;
            core_key2  <= '0;
            core_key3  <= '0;
        end else begin
            core_start <= w_disp_pop;
            if (w_disp_pop) begin
                core_mode <= r_mode;
                core_data <= r_in_mem[r_in_rp];
                core_key1 <= r_key1;
                core_key2 <= r_key2;
                core_key3 <= r_key3;
            end
        end
    end

    always_comb begin
        w_status        = '0;
        w_status[0]     = (r_in_cnt == DEPTH);
        w_status[1]     = (r_in_cnt == '0);
        w_status[2]     = (r_out_cnt == DEPTH);
        w_status[3]     = (r_out_cnt == '0);
        w_status[4]     = (r_state != S_IDLE);
        w_status[12:8]  = 5'(r_in_cnt);
        w_status[20:16] = 5'(r_out_cnt);
    end

    always_comb begin
        HRDATA = '0;
        if (r_dp_rd) begin
            case (r_dp_idx)
                IX_CTRL: HRDATA = {62'b0, r_irq_en, r_mode};
                IX_STAT: HRDATA = w_status;
                IX_KEY1: HRDATA = r_key1;
                IX_KEY2: HRDATA = r_key2;
                IX_KEY3: HRDATA = r_key3;
                IX_DOUT: HRDATA = r_out_mem[r_out_rp];
                default: HRDATA = '0;
            endcase
        end
    end

    assign irq = r_irq_en & (r_out_cnt != '0);

endmodule

// File: tb/tb_ahb_des_queue_slave.sv
// Directed bench for ahb_des_queue_slave with a behavioural DES core stand-in.
module tb_ahb_des_queue_slave;
    logic        HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HREADY;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'b011;
    logic [63:0] HWDATA = '0, HRDATA;
    logic        HREADYOUT, HRESP, core_start, core_mode, core_done = 1'b0, irq;
    logic [63:0] core_data, core_key1, core_key2, core_key3, core_result = '0;

    localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h08, A_KEY1 = 32'h10, A_KEY2 = 32'h18,
                            A_KEY3 = 32'h20, A_DIN = 32'h28, A_DOUT = 32'h30;
    localparam logic [63:0] K1 = 64'h0123_4567_89AB_CDEF, K2 = 64'h1111_2222_3333_4444,
                            K3 = 64'h5555_6666_7777_8888;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_des_queue_slave #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .core_start(core_start), .core_mode(core_mode), .core_data(core_data),
        .core_key1(core_key1), .core_key2(core_key2), .core_key3(core_key3),
        .core_done(core_done), .core_result(core_result), .irq(irq)
    );

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core stand-in: result = ~data ^ key1, returned lat+1 negedges after start
    bit          stall = 1'b0, pend = 1'b0;
    int          lat = 5, cnt = 0, starts = 0;
    logic [63:0] res_q = '0, obs_data = '0, obs_k1 = '0;
    logic        obs_mode = 1'b0;

    initial forever begin
        @(negedge HCLK);
        core_done = 1'b0;
        if (pend && !stall) begin
            if (cnt == 0) begin
                core_done   = 1'b1;
                core_result = res_q;
                pend        = 1'b0;
            end else cnt--;
        end
        if (core_start) begin
            starts++;
            pend     = 1'b1;
            cnt      = lat;
            res_q    = ~core_data ^ core_key1;
            obs_data = core_data;
            obs_mode = core_mode;
            obs_k1   = core_key1;
        end
    end

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [63:0] wd, output logic [63:0] rd, output bit err);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'b011; HWDATA = wd;
        rd  = HRDATA;
        err = HRESP;
        if (err) begin
            chk("err_ph1_ready", {63'b0, HREADYOUT}, 64'd0);
            @(posedge HCLK); #1;
            chk("err_ph2_ready", {63'b0, HREADYOUT}, 64'd1);
            chk("err_ph2_resp", {63'b0, HRESP}, 64'd1);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic wr_ok(input string tag, input logic [31:0] a, input logic [63:0] d);
        logic [63:0] rd; bit err;
        xfer(1'b1, a, 3'b011, d, rd, err);
        chk(tag, {63'b0, err}, 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [63:0] exp);
        logic [63:0] rd; bit err;
        xfer(1'b0, a, 3'b011, '0, rd, err);
        chk(tag, rd, exp);
    endtask

    task automatic expect_err(input string tag, input bit wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [63:0] d);
        logic [63:0] rd; bit err;
        xfer(wr, a, sz, d, rd, err);
        chk(tag, {63'b0, err}, 64'd1);
        chk({tag, "_rdata"}, rd, 64'd0);
    endtask

    logic [63:0] B [6];
    logic [63:0] X, C0, C1, C2, D0, D1, E0, E1;
    bit found;

    initial begin
        X  = 64'hDEAD_BEEF_0000_1111;
        C0 = 64'hC0C0_0000_0000_0000; C1 = 64'hC1C1_0000_0000_0001; C2 = 64'hC2C2_0000_1234_5678;
        D0 = 64'h0D0D_0000_0000_0000; D1 = 64'h0D1D_0000_0000_0001;
        E0 = 64'hE0E0_E0E0_0000_0000; E1 = 64'hE1E1_E1E1_0000_0001;
        for (int i = 0; i < 6; i++) B[i] = 64'hB000_0000_0000_0000 | 64'(i * 17 + 3);

        // Reset state
        #2 HRESET = 1'b0;
        #20;
        chk("rst_hreadyout", {63'b0, HREADYOUT}, 64'd1);
        chk("rst_hresp", {63'b0, HRESP}, 64'd0);
        chk("rst_hrdata", HRDATA, 64'd0);
        chk("rst_core_start", {63'b0, core_start}, 64'd0);
        chk("rst_irq", {63'b0, irq}, 64'd0);
        @(posedge HCLK); #1 HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        rd_chk("rst_status", A_STAT, 64'hA);

        // Single block end to end
        lat = 20;
        wr_ok("wr_key1", A_KEY1, K1);
        wr_ok("wr_key2", A_KEY2, K2);
        wr_ok("wr_key3", A_KEY3, K3);
        wr_ok("wr_ctrl", A_CTRL, 64'd1);
        rd_chk("rd_key1", A_KEY1, K1);
        wr_ok("push_x", A_DIN, X);
        repeat (40) @(posedge HCLK);
        #1;
        chk("one_start", 64'(starts), 64'd1);
        chk("core_data_x", obs_data, X);
        chk("core_mode_enc", {63'b0, obs_mode}, 64'd1);
        chk("core_key1", obs_k1, K1);
        chk("core_key2_held", core_key2, K2);
        rd_chk("status_out1", A_STAT, 64'h10002);
        rd_chk("dout_x", A_DOUT, ~X ^ K1);
        rd_chk("status_empty", A_STAT, 64'hA);

        // Input queue overflow with the core stalled on the first block
        stall = 1'b1; lat = 3;
        for (int i = 0; i < 5; i++) wr_ok("push_b", A_DIN, B[i]);
        expect_err("push_full", 1'b1, A_DIN, 3'b011, B[5]);
        rd_chk("status_in_full", A_STAT, 64'h419);
        chk("starts_stalled", 64'(starts), 64'd2);

        // Illegal accesses
        expect_err("rd_dout_empty", 1'b0, A_DOUT, 3'b011, '0);
        expect_err("rd_unmapped", 1'b0, 32'h38, 3'b011, '0);
        expect_err("wr_key1_size", 1'b1, A_KEY1, 3'b010, 64'hFFFF);
        expect_err("wr_status", 1'b1, A_STAT, 3'b011, 64'hFF);
        expect_err("rd_din", 1'b0, A_DIN, 3'b011, '0);
        rd_chk("key1_unchanged", A_KEY1, K1);
        rd_chk("status_unchanged", A_STAT, 64'h419);

        // Output queue backpressure
        stall = 1'b0;
        repeat (100) @(posedge HCLK);
        #1;
        chk("starts_out_full", 64'(starts), 64'd5);
        rd_chk("status_out_full", A_STAT, 64'h40104);
        repeat (20) @(posedge HCLK);
        #1;
        chk("no_start_when_full", 64'(starts), 64'd5);
        rd_chk("dout_b0", A_DOUT, ~B[0] ^ K1);
        repeat (30) @(posedge HCLK);
        #1;
        chk("start_after_pop", 64'(starts), 64'd6);
        rd_chk("status_refill", A_STAT, 64'h40006);
        for (int i = 1; i < 5; i++) rd_chk("dout_b", A_DOUT, ~B[i] ^ K1);
        rd_chk("status_drained", A_STAT, 64'hA);

        // Flush while BUSY
        stall = 1'b1;
        wr_ok("push_c0", A_DIN, C0);
        repeat (3) @(posedge HCLK);
        #1;
        wr_ok("push_c1", A_DIN, C1);
        wr_ok("wr_flush", A_CTRL, 64'd5);
        rd_chk("status_drain", A_STAT, 64'h1A);
        rd_chk("ctrl_flush_rd0", A_CTRL, 64'd1);
        stall = 1'b0;
        repeat (20) @(posedge HCLK);
        #1;
        rd_chk("status_discard", A_STAT, 64'hA);
        chk("starts_flush", 64'(starts), 64'd7);
        wr_ok("push_c2", A_DIN, C2);
        repeat (20) @(posedge HCLK);
        #1;
        chk("starts_after_flush", 64'(starts), 64'd8);
        rd_chk("dout_c2", A_DOUT, ~C2 ^ K1);

        // Interrupt
        wr_ok("wr_irq_en", A_CTRL, 64'd3);
        chk("irq_idle", {63'b0, irq}, 64'd0);
        wr_ok("push_d0", A_DIN, D0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge HCLK); #1;
            if (core_done) begin
                found = 1'b1;
                chk("irq_before_push", {63'b0, irq}, 64'd0);
                @(posedge HCLK); #1;
                chk("irq_after_push", {63'b0, irq}, 64'd1);
            end
        end
        if (!found) chk("irq_done_seen", 64'd0, 64'd1);
        @(posedge HCLK); #1;
        wr_ok("push_d1", A_DIN, D1);
        repeat (20) @(posedge HCLK);
        #1;
        rd_chk("dout_d0", A_DOUT, ~D0 ^ K1);
        chk("irq_one_left", {63'b0, irq}, 64'd1);
        rd_chk("dout_d1", A_DOUT, ~D1 ^ K1);
        chk("irq_cleared", {63'b0, irq}, 64'd0);

        // Reset in the middle of a block
        lat = 3;
        wr_ok("push_e0", A_DIN, E0);
        repeat (15) @(posedge HCLK);
        #1;
        chk("irq_pre_reset", {63'b0, irq}, 64'd1);
        lat = 30;
        wr_ok("push_e1", A_DIN, E1);
        repeat (5) @(posedge HCLK);
        #2 HRESET = 1'b0;
        #1;
        chk("mid_rst_hreadyout", {63'b0, HREADYOUT}, 64'd1);
        chk("mid_rst_hresp", {63'b0, HRESP}, 64'd0);
        chk("mid_rst_hrdata", HRDATA, 64'd0);
        chk("mid_rst_core_start", {63'b0, core_start}, 64'd0);
        chk("mid_rst_core_mode", {63'b0, core_mode}, 64'd0);
        chk("mid_rst_core_data", core_data, 64'd0);
        chk("mid_rst_core_key1", core_key1, 64'd0);
        chk("mid_rst_irq", {63'b0, irq}, 64'd0);
        @(posedge HCLK); #1 HRESET = 1'b1;
        repeat (50) @(posedge HCLK);
        #1;
        rd_chk("post_rst_status", A_STAT, 64'hA);
        rd_chk("post_rst_key1", A_KEY1, 64'd0);
        rd_chk("post_rst_ctrl", A_CTRL, 64'd0);
        chk("post_rst_starts", 64'(starts), 64'd12);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
